// File: rtl/conv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : conv_pkg
//  Description : Shared sizing helpers and strobe bundle type for the
//                convolution block, its sequencer and its BRAM instances.
//  Revision    : 1.0  initial release
// ============================================================================
package conv_pkg;

    // Output grid side length for a square feature map and kernel.
    function automatic int calc_out_size(input int fm, input int k, input int p, input int s);
        return ((fm - k + 2 * p) / s) + 1;
    endfunction

    // Bits needed to index n items; never narrower than one bit so that
    // degenerate sizes still give a legal vector.
    function automatic int addr_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Per-tap control flags carried alongside the BRAM read.
    typedef struct packed {
        logic pad;
        logic mac_en;
        logic mac_clr;
        logic out_valid;
    } tap_strb_t;

endpackage
`default_nettype wire

// File: rtl/conv_tap_delay.sv
`default_nettype none
// ============================================================================
//  Module      : conv_tap_delay
//  Description : Fixed-depth shift register that re-times per-tap control
//                so it lines up with BRAM read data. Shifts every cycle;
//                a zero word entering the head acts as a bubble.
//  Ports       : i_clk    clock
//                i_rst_n  asynchronous active-low reset
//                i_d      word entering the pipe this cycle
//                o_q      word that entered DEPTH cycles ago
//  Revision    : 1.0  initial release
// ============================================================================
module conv_tap_delay #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [DEPTH-1:0][WIDTH-1:0] pipe_q;
    logic [DEPTH-1:0][WIDTH-1:0] pipe_d;

    always_comb begin
        pipe_d    = pipe_q;
        pipe_d[0] = i_d;
        for (int i = 1; i < DEPTH; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pipe_q <= '0;
        end else begin
            pipe_q <= pipe_d;
        end
    end

    assign o_q = pipe_q[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/conv_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : conv_seq_ctrl
//  Description : Tap sequencer for conv_blk. Walks the output grid and the
//                kernel window one tap per cycle, issues feature-map and
//                weight BRAM addresses, and emits MAC strobes aligned with
//                the BRAM read data. Taps falling in the zero border are
//                flagged so the datapath substitutes zero.
//  Ports       : i_clk, i_rst_n       clock, async active-low reset
//                i_go                 frame start (sampled in IDLE)
//                i_stall              hold address issue this cycle
//                o_busy, o_done       RUN/DRAIN status, end-of-frame pulse
//                o_rd_en              read strobe for both BRAMs
//                o_fm_addr, o_w_addr  row-major read addresses
//                o_pad, o_mac_en,     strobes aligned with read data
//                o_mac_clr, o_out_valid
//                o_out_row, o_out_col output coordinate (with o_out_valid)
//  Revision    : 1.0  initial release
// ============================================================================
module conv_seq_ctrl
    import conv_pkg::*;
#(
    parameter  int KERNEL_SIZE  = 3,
    parameter  int FM_SIZE      = 8,
    parameter  int PADDING      = 0,
    parameter  int STRIDE       = 1,
    parameter  int BRAM_LATENCY = 1,
    localparam int OUT_SIZE     = calc_out_size(FM_SIZE, KERNEL_SIZE, PADDING, STRIDE),
    localparam int FA_W         = addr_width(FM_SIZE * FM_SIZE),
    localparam int WA_W         = addr_width(KERNEL_SIZE * KERNEL_SIZE),
    localparam int OC_W         = addr_width(OUT_SIZE)
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_go,
    input  logic            i_stall,
    output logic            o_busy,
    output logic            o_done,
    output logic            o_rd_en,
    output logic [FA_W-1:0] o_fm_addr,
    output logic [WA_W-1:0] o_w_addr,
    output logic            o_pad,
    output logic            o_mac_en,
    output logic            o_mac_clr,
    output logic            o_out_valid,
    output logic [OC_W-1:0] o_out_row,
    output logic [OC_W-1:0] o_out_col
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam int KC_W   = addr_width(KERNEL_SIZE);
    localparam int DC_W   = addr_width(BRAM_LATENCY);
    localparam int STRB_W = $bits(tap_strb_t) + 2 * OC_W;

    logic [1:0]      state_q, state_d;
    logic [KC_W-1:0] kc_q, kc_d;
    logic [KC_W-1:0] kr_q, kr_d;
    logic [OC_W-1:0] oc_q, oc_d;
    logic [OC_W-1:0] orow_q, orow_d;
    logic [DC_W-1:0] drain_q, drain_d;

    logic issue;
    logic kc_last, kr_last, oc_last, orow_last, tap_last;
    int   in_y, in_x, fm_lin, w_lin;
    logic in_bounds;

    tap_strb_t         strb_in, strb_out;
    logic [OC_W-1:0]   row_in, col_in;
    logic [STRB_W-1:0] dly_in, dly_out;

    assign issue     = (state_q == ST_RUN) && !i_stall;
    assign kc_last   = (kc_q == KC_W'(KERNEL_SIZE - 1));
    assign kr_last   = (kr_q == KC_W'(KERNEL_SIZE - 1));
    assign oc_last   = (oc_q == OC_W'(OUT_SIZE - 1));
    assign orow_last = (orow_q == OC_W'(OUT_SIZE - 1));
    assign tap_last  = kc_last && kr_last && oc_last && orow_last;

    // Input-plane coordinate of the current tap. Evaluated as 32-bit signed
    // so taps left of / above the map come out negative.
    always_comb begin
        in_y      = int'(orow_q) * STRIDE + int'(kr_q) - PADDING;
        in_x      = int'(oc_q) * STRIDE + int'(kc_q) - PADDING;
        in_bounds = (in_y >= 0) && (in_y < FM_SIZE) && (in_x >= 0) && (in_x < FM_SIZE);
        fm_lin    = in_y * FM_SIZE + in_x;
        w_lin     = int'(kr_q) * KERNEL_SIZE + int'(kc_q);
    end

    // Frame state and tap counters (kc fastest, then kr, oc, row).
    always_comb begin
        state_d = state_q;
        kc_d    = kc_q;
        kr_d    = kr_q;
        oc_d    = oc_q;
        orow_d  = orow_q;
        drain_d = drain_q;
        case (state_q)
            ST_IDLE: begin
                if (i_go) begin
                    state_d = ST_RUN;
                    kc_d    = '0;
                    kr_d    = '0;
                    oc_d    = '0;
                    orow_d  = '0;
                end
            end
            ST_RUN: begin
                if (issue) begin
                    if (!kc_last) begin
                        kc_d = kc_q + KC_W'(1);
                    end else begin
                        kc_d = '0;
                        if (!kr_last) begin
                            kr_d = kr_q + KC_W'(1);
                        end else begin
                            kr_d = '0;
                            if (!oc_last) begin
                                oc_d = oc_q + OC_W'(1);
                            end else begin
                                oc_d   = '0;
                                orow_d = orow_last ? '0 : orow_q + OC_W'(1);
                            end
                        end
                    end
                    if (tap_last) begin
                        state_d = ST_DRAIN;
                        drain_d = '0;
                    end
                end
            end
            ST_DRAIN: begin
                // Hold until the last read's data has left the delay line.
                if (drain_q == DC_W'(BRAM_LATENCY - 1)) begin
                    state_d = ST_DONE;
                end else begin
                    drain_d = drain_q + DC_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            kc_q    <= '0;
            kr_q    <= '0;
            oc_q    <= '0;
            orow_q  <= '0;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            kc_q    <= kc_d;
            kr_q    <= kr_d;
            oc_q    <= oc_d;
            orow_q  <= orow_d;
            drain_q <= drain_d;
        end
    end

    // Everything entering the delay line is qualified by issue, so a stall
    // cycle pushes an all-zero bubble.
    always_comb begin
        strb_in.pad       = issue && !in_bounds;
        strb_in.mac_en    = issue;
        strb_in.mac_clr   = issue && (kc_q == '0) && (kr_q == '0);
        strb_in.out_valid = issue && kc_last && kr_last;
        row_in            = strb_in.out_valid ? orow_q : '0;
        col_in            = strb_in.out_valid ? oc_q : '0;
    end

    assign dly_in = {strb_in, row_in, col_in};

    conv_tap_delay #(
        .WIDTH (STRB_W),
        .DEPTH (BRAM_LATENCY)
    ) u_tap_delay (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_d     (dly_in),
        .o_q     (dly_out)
    );

    assign strb_out  = dly_out[STRB_W-1 -: $bits(tap_strb_t)];
    assign o_out_row = dly_out[2*OC_W-1 -: OC_W];
    assign o_out_col = dly_out[OC_W-1:0];

    assign o_pad       = strb_out.pad;
    assign o_mac_en    = strb_out.mac_en;
    assign o_mac_clr   = strb_out.mac_clr;
    assign o_out_valid = strb_out.out_valid;

    assign o_busy    = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign o_done    = (state_q == ST_DONE);
    assign o_rd_en   = issue;
    assign o_fm_addr = (issue && in_bounds) ? FA_W'(fm_lin) : '0;
    assign o_w_addr  = issue ? WA_W'(w_lin) : '0;

endmodule
`default_nettype wire

// File: doc/conv_seq_ctrl.md
Name: conv_seq_ctrl

Overview:
- Sequencer for conv_blk: walks the output grid and the kernel window tap by tap.
- Issues feature-map and weight BRAM read addresses, one tap per cycle.
- Emits MAC control strobes aligned to BRAM read data, and flags padding taps so the datapath substitutes zero.
- Sits between the top-level go/done handshake and the feature-map/weight BRAMs plus the conv_blk MAC.

Parameters:
KERNEL_SIZE, 3, kernel side length K (>=1)
FM_SIZE, 8, input feature-map side length (>=K-2*PADDING)
PADDING, 0, zero-padding on each border (0..K-1)
STRIDE, 1, window step (>=1)
BRAM_LATENCY, 1, read latency of both BRAMs in cycles (>=1)
localparam OUT_SIZE = ((FM_SIZE-KERNEL_SIZE+2*PADDING)/STRIDE)+1

Ports:
i_clk  in  1  clock, all logic rising-edge
i_rst_n  in  1  asynchronous active-low reset
i_go  in  1  start request, level-sampled in IDLE only
i_stall  in  1  hold address issue this cycle
o_busy  out  1  high in RUN and DRAIN
o_done  out  1  one-cycle pulse at end of frame
o_rd_en  out  1  read strobe for both BRAMs
o_fm_addr  out  clog2(FM_SIZE**2)  row-major feature-map address
o_w_addr  out  clog2(KERNEL_SIZE**2)  row-major weight address
o_pad  out  1  tap lies in padding; aligned with read data
o_mac_en  out  1  accumulate this tap; aligned with read data
o_mac_clr  out  1  first tap of a window; load instead of add
o_out_valid  out  1  last tap of a window accumulated this cycle
o_out_row, o_out_col  out  max(1,clog2(OUT_SIZE))  output coordinate; valid with o_out_valid

Behaviour:
- Reset: all outputs 0, FSM in IDLE, counters 0. Reset assertion mid-frame aborts immediately; no o_done is produced.
- FSM transitions:
  - IDLE -> RUN when i_go=1.
  - RUN -> DRAIN after the last tap is issued.
  - DRAIN lasts BRAM_LATENCY cycles, then goes to DONE.
  - DONE lasts one cycle with o_done=1, then goes to IDLE.
  - i_go is ignored outside IDLE. If i_go is held high, a new frame starts the cycle after DONE.
- Counters, fastest first: kc, kr (0..K-1), oc, or (0..OUT_SIZE-1).
- Input coordinate of a tap: y = or*STRIDE + kr - PADDING, x = oc*STRIDE + kc - PADDING. Use signed arithmetic with a width sufficient for -PADDING.
- In RUN with i_stall=0, one tap is issued per cycle:
  - o_rd_en=1, o_w_addr = kr*K + kc.
  - If 0<=y<FM_SIZE and 0<=x<FM_SIZE: o_fm_addr = y*FM_SIZE + x and the pad flag is 0.
  - Otherwise: o_fm_addr = 0 and the pad flag is 1.
- i_stall=1 in RUN: o_rd_en=0 and the counters hold. The delay line still shifts, inserting a bubble.
- Total taps per frame = OUT_SIZE^2 * K^2. The first issue occurs the cycle after i_go is sampled.
- Delay line of depth BRAM_LATENCY carries pad, mac_en, mac_clr, out_valid and the output coordinate.
  - mac_clr marks kr=kc=0; out_valid marks kr=kc=K-1.
  - Each strobe appears exactly BRAM_LATENCY cycles after its o_rd_en.
  - When K=1, mac_clr and out_valid coincide on every tap.
- The last o_rd_en occurs in cycle N. Its o_out_valid is in N+L. o_done is in N+L+1 (L = BRAM_LATENCY).
- i_stall has no effect in DRAIN or DONE.

Decomposition:
- Shared package conv_pkg: OUT_SIZE computation function and address-width helper functions; reused by conv_blk and bram instances.
- One natural sub-module: conv_tap_delay, a parametric shift register carrying the aligned strobes.

Test Plan:
- K=3, FM=4, P=0, S=1, L=1, pulse i_go:
  - 36 consecutive o_rd_en.
  - First window fm addrs 0,1,2,4,5,6,8,9,10; w addrs 0..8.
  - 4 o_out_valid pulses with (row,col) = (0,0),(0,1),(1,0),(1,1).
  - o_done exactly 2 cycles after the last o_rd_en.
- K=3, FM=4, P=1, S=1:
  - OUT=4, 144 taps.
  - First window: o_pad=1 on taps 0,1,2,3,6.
  - Taps 4,5,7,8 read addrs 0,1,4,5.
- K=2, FM=4, P=0, S=2: window origins at addrs 0,2,8,10; first window taps 0,1,4,5.
- Same as scenario 1 with i_stall high for 3 cycles mid-window:
  - o_rd_en count is still 36.
  - The address sequence is unchanged.
  - o_done is delayed by 3 cycles.
- Set L=2: every o_mac_en/o_out_valid lags its o_rd_en by exactly 2 cycles.
- Deassert i_rst_n mid-RUN:
  - All outputs 0 immediately.
  - No o_done.
  - After release plus i_go, the frame restarts from address 0.
- i_go held high: back-to-back frames separated by exactly one IDLE cycle after DONE.
